// File: rtl/vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vid_timing_gen
// Purpose  : Raster timing generator with pixel divider, per-frame shadowed
//            timing set and FIFO-fed RGB output. Define VID_TIMING_UNDERFLOW_EN
//            to build the sticky FIFO-underrun flag; otherwise underflow is 0.
// Revision : 1.0
// ============================================================================
module vid_timing_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [5:0]  pcnt,
    input  logic [12:0] hend,
    input  logic [12:0] hsize,
    input  logic [12:0] hss,
    input  logic [12:0] hse,
    input  logic [12:0] vend,
    input  logic [12:0] vsize,
    input  logic [12:0] vss,
    input  logic [12:0] vse,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_rdata,
    output logic        fifo_read,
    output logic        hsync,
    output logic        hblank,
    output logic        vsync,
    output logic        vblank,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        frame_start,
    output logic        underflow
);

    logic        r_en_d;
    logic [5:0]  r_div;
    logic [12:0] r_hcnt;
    logic [12:0] r_vcnt;

    logic [5:0]  r_pcnt;
    logic [12:0] r_hend;
    logic [12:0] r_hsize;
    logic [12:0] r_hss;
    logic [12:0] r_hse;
    logic [12:0] r_vend;
    logic [12:0] r_vsize;
    logic [12:0] r_vss;
    logic [12:0] r_vse;

    logic        r_hsync;
    logic        r_hblank;
    logic        r_vsync;
    logic        r_vblank;
    logic        r_frame_start;
    logic [23:0] r_rgb;

    logic        w_start;
    logic        w_tick;
    logic        w_hblank;
    logic        w_vblank;
    logic        w_active;
    logic        w_pop;
    logic        w_line_end;
    logic        w_frame_end;
    logic        w_capture;

    // r_en_d is cleared by reset, so reset release with en=1 looks like en rising
    assign w_start     = en & ~r_en_d;
    assign w_tick      = en & r_en_d & (r_div == r_pcnt);
    assign w_hblank    = (r_hcnt >= r_hsize);
    assign w_vblank    = (r_vcnt >= r_vsize);
    assign w_active    = ~w_hblank & ~w_vblank;
    assign w_pop       = w_tick & w_active & ~fifo_empty;
    assign w_line_end  = (r_hcnt == r_hend);
    assign w_frame_end = w_line_end & (r_vcnt == r_vend);
    assign w_capture   = w_start | (w_tick & w_frame_end);

    // Pop is issued in the tick clock itself so the show-ahead head is
    // consumed exactly at the edge that latches it, even with pcnt=0.
    assign fifo_read = w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt  <= '0;
            r_hend  <= '0;
            r_hsize <= '0;
            r_hss   <= '0;
            r_hse   <= '0;
            r_vend  <= '0;
            r_vsize <= '0;
            r_vss   <= '0;
            r_vse   <= '0;
        end else if (w_capture) begin
            r_pcnt  <= pcnt;
            r_hend  <= hend;
            r_hsize <= hsize;
            r_hss   <= hss;
            r_hse   <= hse;
            r_vend  <= vend;
            r_vsize <= vsize;
            r_vss   <= vss;
            r_vse   <= vse;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d        <= 1'b0;
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hsync       <= 1'b0;
            r_hblank      <= 1'b0;
            r_vsync       <= 1'b0;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else if (!en || !r_en_d) begin
            // Disabled, or first enabled clock: park at the raster origin
            r_en_d        <= en;
            r_div         <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hsync       <= 1'b0;
            r_hblank      <= 1'b0;
            r_vsync       <= 1'b0;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_div         <= '0;
                r_hblank      <= w_hblank;
                r_vblank      <= w_vblank;
                r_hsync       <= (r_hcnt >= r_hss) && (r_hcnt < r_hse);
                r_vsync       <= (r_vcnt >= r_vss) && (r_vcnt < r_vse);
                r_frame_start <= (r_hcnt == 13'd0) && (r_vcnt == 13'd0);
                r_rgb         <= w_pop ? fifo_rdata : 24'd0;
                if (w_line_end) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_frame_end ? 13'd0 : (r_vcnt + 13'd1);
                end else begin
                    r_hcnt <= r_hcnt + 13'd1;
                end
            end else begin
                r_div <= r_div + 6'd1;
            end
        end
    end

`ifdef VID_TIMING_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
        end else if (w_start) begin
            r_underflow <= 1'b0;
        end else if (w_tick && w_active && fifo_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign underflow = r_underflow;
`else
    assign underflow = 1'b0;
`endif

    assign hsync       = r_hsync;
    assign hblank      = r_hblank;
    assign vsync       = r_vsync;
    assign vblank      = r_vblank;
    assign frame_start = r_frame_start;
    assign R           = r_rgb[23:16];
    assign G           = r_rgb[15:8];
    assign B           = r_rgb[7:0];

endmodule
`default_nettype wire

// File: doc/vid_timing_gen.md
VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port en, input, 1 bit: controller enable (CR bit 3).
REQ-004 SHALL have port pcnt, input, 6 bits: pixel divider; one pixel per pcnt+1 clocks.
REQ-005 SHALL have ports hend, hsize, hss, hse, input, 13 bits each: last pixel index, displayed pixels, hsync start, hsync end.
REQ-006 SHALL have ports vend, vsize, vss, vse, input, 13 bits each: last line index, displayed lines, vsync start, vsync end.
REQ-007 SHALL have port fifo_empty, input, 1 bit: pixel FIFO empty flag.
REQ-008 SHALL have port fifo_rdata, input, 24 bits: show-ahead FIFO head; [23:16]=R, [15:8]=G, [7:0]=B.
REQ-009 SHALL have port fifo_read, output, 1 bit: one-clock pop strobe.
REQ-010 SHALL have ports hsync, hblank, vsync, vblank, output, 1 bit each, active high.
REQ-011 SHALL have ports R, G, B, output, 8 bits each.
REQ-012 SHALL have port frame_start, output, 1 bit: one-clock pulse at pixel (0,0).
REQ-013 SHALL have port underflow, output, 1 bit: sticky FIFO-underrun flag.

Function
REQ-014 Divider counter SHALL count 0..pcnt and wrap; pixel tick asserts on the clock where it equals pcnt (pcnt=0: tick every clock).
REQ-015 hcnt SHALL advance on each tick, wrap hend->0; vcnt SHALL advance on hcnt wrap, wrap vend->0; 13-bit unsigned.
REQ-016 hblank = (hcnt >= hsize); vblank = (vcnt >= vsize); active = !hblank && !vblank.
REQ-017 hsync = (hss <= hcnt < hse); vsync = (vss <= vcnt < vse); hss >= hse or vss >= vse SHALL give sync never asserted.
REQ-018 All outputs SHALL be registered, one clock after the tick they describe, and held between ticks.
REQ-019 On a tick in active region with fifo_empty=0: fifo_read=1 for that single clock; next clock R/G/B = fifo_rdata fields.
REQ-020 On a tick in active region with fifo_empty=1: no pop, R/G/B=0, underflow set.
REQ-021 In blanking R/G/B SHALL be 0 and fifo_read SHALL be 0.
REQ-022 fifo_read SHALL never assert on a non-tick clock or more than once per pixel.
REQ-023 Timing inputs SHALL be captured into shadow registers at en rising and at each frame wrap (hcnt=hend, vcnt=vend tick); mid-frame input changes SHALL not affect the current frame.
REQ-024 frame_start SHALL pulse for one clock with the output update for pixel (0,0).
REQ-025 en=0 SHALL synchronously clear counters to 0 and drive all outputs 0 on the next clock; no pops; underflow retained.
REQ-026 en rising SHALL start at divider=0, hcnt=0, vcnt=0; first tick after pcnt+1 clocks.
REQ-027 underflow SHALL clear only on reset or on en rising.

Reset
REQ-028 reset_n=0 SHALL immediately clear divider, hcnt, vcnt, shadow registers and all outputs, including underflow, to 0, irrespective of clk.
REQ-029 Reset release SHALL behave as en rising if en=1 at the first clock edge.

Configuration
REQ-030 Macro VID_TIMING_UNDERFLOW_EN defined: underflow behaves per REQ-020/027.
REQ-031 Macro VID_TIMING_UNDERFLOW_EN undefined: underflow tied 0, no tracking logic; empty-FIFO active pixels still output 0.

Verification
REQ-032 pcnt=0, hend=9, hsize=6, hss=7, hse=8, vend=4, vsize=3, vss=3, vse=4, FIFO primed -> line 10 clocks, hblank pixels 6-9, hsync pixel 7 only, vblank lines 3-4, frame 50 clocks.
REQ-033 pcnt=2, same timing -> each output held 3 clocks, fifo_read pulse every 3rd clock in active region, 18 pops per frame.
REQ-034 FIFO holds 0x112233, 0x445566 then empty, active line -> R/G/B = 11/22/33, 44/55/66, then 0 with underflow=1 and no further fifo_read.
REQ-035 Change hend 9->19 mid-frame -> current frame keeps 10-pixel lines; next frame after frame_start uses 20.
REQ-036 reset_n low mid-line between clock edges -> all outputs 0 without a clock edge; after release with en=1, frame_start one clock after first tick.
REQ-037 hss=8, hse=8 and en dropped mid-frame -> hsync never asserted; all outputs 0 one clock after en=0, underflow unchanged.
